// File: rtl/mdu_sequencer_if.sv
// E-stage bundle between the pipeline and the multiply/divide sequencer.
// The master side drives the decoded E/D-stage requests and operands;
// the slave side (the MDU) returns busy, HI/LO and the D-stage stall.
interface mdu_sequencer_if;
  logic        E_md;
  logic        E_mt;
  logic [2:0]  E_MDU_op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_mdu;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        stall;

  modport master (
    output E_md, E_mt, E_MDU_op, E_A, E_B, D_mdu,
    input  busy, HI, LO, stall
  );

  modport slave (
    input  E_md, E_mt, E_MDU_op, E_A, E_B, D_mdu,
    output busy, HI, LO, stall
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer for the E stage of the five-stage MIPS pipeline.
// Owns HI/LO. A mult/div computes its result at the start edge into temp
// registers, then holds busy for a fixed number of cycles before committing
// the temp result to HI/LO. mthi/mtlo write HI/LO directly when idle.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  mdu_sequencer_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  localparam logic [2:0] OP_MULT  = 3'b011;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b101;
  localparam logic [2:0] OP_DIVU  = 3'b100;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // State and datapath registers
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_thi;
  logic [31:0]      r_tlo;

  // Next-state values
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_busy_nxt;
  logic [31:0]      w_hi_nxt;
  logic [31:0]      w_lo_nxt;
  logic [31:0]      w_thi_nxt;
  logic [31:0]      w_tlo_nxt;

  // Arithmetic results for the current E-stage operands
  logic signed [63:0] w_smul;
  logic        [63:0] w_umul;
  logic signed [31:0] w_squo;
  logic signed [31:0] w_srem;
  logic        [31:0] w_uquo;
  logic        [31:0] w_urem;
  logic               w_div0;

  // Selected result and busy length for the requested operation
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic [CNT_W-1:0] w_load;

  // Products and quotients; the divider is bypassed on a zero divisor so no
  // undefined division result ever reaches the temp registers.
  always_comb begin
    w_div0 = (bus.E_B == 32'd0);
    w_smul = $signed({{32{bus.E_A[31]}}, bus.E_A}) * $signed({{32{bus.E_B[31]}}, bus.E_B});
    w_umul = {32'd0, bus.E_A} * {32'd0, bus.E_B};
    if (w_div0) begin
      w_squo = 32'sd0;
      w_srem = 32'sd0;
      w_uquo = 32'd0;
      w_urem = 32'd0;
    end else begin
      w_squo = $signed(bus.E_A) / $signed(bus.E_B);
      w_srem = $signed(bus.E_A) % $signed(bus.E_B);
      w_uquo = bus.E_A / bus.E_B;
      w_urem = bus.E_A % bus.E_B;
    end
  end

  // Pick the result and cycle count for the opcode; unknown opcodes act as
  // multu, and a zero divisor re-captures current HI/LO so the commit is a no-op.
  always_comb begin
    w_res_hi = w_umul[63:32];
    w_res_lo = w_umul[31:0];
    w_load   = MULT_LOAD;
    case (bus.E_MDU_op)
      OP_MULT: begin
        w_res_hi = w_smul[63:32];
        w_res_lo = w_smul[31:0];
      end
      OP_MULTU: begin
        w_res_hi = w_umul[63:32];
        w_res_lo = w_umul[31:0];
      end
      OP_DIV: begin
        w_load = DIV_LOAD;
        if (w_div0) begin
          w_res_hi = r_hi;
          w_res_lo = r_lo;
        end else begin
          w_res_hi = w_srem;
          w_res_lo = w_squo;
        end
      end
      OP_DIVU: begin
        w_load = DIV_LOAD;
        if (w_div0) begin
          w_res_hi = r_hi;
          w_res_lo = r_lo;
        end else begin
          w_res_hi = w_urem;
          w_res_lo = w_uquo;
        end
      end
      default: begin
        w_res_hi = w_umul[63:32];
        w_res_lo = w_umul[31:0];
      end
    endcase
  end

  // Sequencer next-state: start, count down, commit; mt writes only when idle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_thi_nxt   = r_thi;
    w_tlo_nxt   = r_tlo;
    case (r_state)
      S_IDLE: begin
        if (bus.E_md) begin
          w_state_nxt = S_BUSY;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = w_load;
          w_thi_nxt   = w_res_hi;
          w_tlo_nxt   = w_res_lo;
        end else if (bus.E_mt) begin
          if (bus.E_MDU_op[0]) begin
            w_hi_nxt = bus.E_A;
          end else begin
            w_lo_nxt = bus.E_A;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if ((r_cnt == CNT_ONE) || (r_cnt == CNT_ZERO)) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = CNT_ZERO;
          w_hi_nxt    = r_thi;
          w_lo_nxt    = r_tlo;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter, busy flag, HI/LO and pending-result registers; reset discards any in-flight result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= CNT_ZERO;
      r_busy <= 1'b0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_thi  <= 32'd0;
      r_tlo  <= 32'd0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= w_busy_nxt;
      r_hi   <= w_hi_nxt;
      r_lo   <= w_lo_nxt;
      r_thi  <= w_thi_nxt;
      r_tlo  <= w_tlo_nxt;
    end
  end

  assign bus.busy  = r_busy;
  assign bus.HI    = r_hi;
  assign bus.LO    = r_lo;
  // Stall covers the start cycle (E_md) and every busy cycle
  assign bus.stall = bus.D_mdu & (bus.E_md | r_busy);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed cases from the test plan
// followed by randomized mult/div/mt traffic checked against an arithmetic model.
module tb_mdu_sequencer;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_sequencer_if bus ();

  mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  // Reference: {HI,LO} after an operation, from plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'b011: res = sa * sb;
      3'b101: begin
        if (b == 32'd0) res = {hi, lo};
        else begin
          q = sa / sb;
          r = sa - q * sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'b100: begin
        if (b == 32'd0) res = {hi, lo};
        else begin
          uq = ua / ub;
          ur = ua - uq * ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
      default: res = ua * ub;
    endcase
    return res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmdu, input logic both, input string tag);
    logic [63:0] r;
    int n;
    r = model(op, a, b, m_hi, m_lo);
    n = (op == 3'b101 || op == 3'b100) ? DC : MC;
    bus.E_md = 1'b1; bus.E_mt = both; bus.E_MDU_op = op;
    bus.E_A = a; bus.E_B = b; bus.D_mdu = dmdu;
    #1;
    chk({tag, "_stall_start"}, 32'(bus.stall), 32'(dmdu));
    chk({tag, "_busy_pre"}, 32'(bus.busy), 32'd0);
    tick();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_busy_c%0d", tag, k), 32'(bus.busy), 32'd1);
      chk($sformatf("%s_stall_c%0d", tag, k), 32'(bus.stall), 32'(dmdu));
      chk($sformatf("%s_hi_hold_c%0d", tag, k), bus.HI, m_hi);
      chk($sformatf("%s_lo_hold_c%0d", tag, k), bus.LO, m_lo);
      // Requests while busy must be ignored
      bus.E_md = 1'($urandom_range(0, 1));
      bus.E_mt = 1'($urandom_range(0, 1));
      bus.E_MDU_op = 3'($urandom_range(0, 7));
      bus.E_A = $urandom;
      bus.E_B = $urandom;
      tick();
    end
    bus.E_md = 1'b0; bus.E_mt = 1'b0;
    #1;
    m_hi = r[63:32];
    m_lo = r[31:0];
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_stall_done"}, 32'(bus.stall), 32'd0);
    chk({tag, "_hi"}, bus.HI, m_hi);
    chk({tag, "_lo"}, bus.LO, m_lo);
  endtask

  task automatic run_mt(input logic sel_hi, input logic [31:0] a, input string tag);
    bus.E_md = 1'b0; bus.E_mt = 1'b1; bus.E_MDU_op = {2'b00, sel_hi};
    bus.E_A = a; bus.E_B = $urandom; bus.D_mdu = 1'($urandom_range(0, 1));
    tick();
    bus.E_mt = 1'b0;
    if (sel_hi) m_hi = a;
    else m_lo = a;
    chk({tag, "_hi"}, bus.HI, m_hi);
    chk({tag, "_lo"}, bus.LO, m_lo);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    reset = 1'b1;
    bus.E_md = 1'b0; bus.E_mt = 1'b0; bus.E_MDU_op = 3'd0;
    bus.E_A = 32'd0; bus.E_B = 32'd0; bus.D_mdu = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) tick();
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    reset = 1'b0;
    tick();

    run_md(3'b011, 32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, "mult_neg");
    run_md(3'b100, 32'd7, 32'd2, 1'b0, 1'b0, "divu_7_2");
    run_md(3'b101, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, "div_neg");
    run_mt(1'b1, 32'h12345678, "mthi");
    run_mt(1'b0, 32'd9, "mtlo");
    run_md(3'b011, 32'd6, 32'd7, 1'b0, 1'b0, "mult_nostall");
    run_mt(1'b1, 32'hAA, "pre_hi");
    run_mt(1'b0, 32'hBB, "pre_lo");
    run_md(3'b100, 32'd100, 32'd0, 1'b1, 1'b0, "divu_zero");
    run_md(3'b101, 32'hFFFFFF00, 32'd0, 1'b0, 1'b0, "div_zero");
    run_md(3'b011, 32'd3, 32'hFFFFFFFC, 1'b1, 1'b1, "md_mt_both");
    run_md(3'b111, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, "unk_op");

    // Reset in the third busy cycle of a mult
    bus.E_md = 1'b1; bus.E_MDU_op = 3'b011; bus.E_A = 32'd7; bus.E_B = 32'd9; bus.D_mdu = 1'b0;
    tick();
    bus.E_md = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_hi", bus.HI, 32'd0);
    chk("midrst_lo", bus.LO, 32'd0);
    #2;
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (4) tick();
    chk("midrst_nocommit_hi", bus.HI, 32'd0);
    chk("midrst_nocommit_lo", bus.LO, 32'd0);
    chk("midrst_nocommit_busy", 32'(bus.busy), 32'd0);
    run_md(3'b011, 32'h00010000, 32'h00010000, 1'b1, 1'b0, "after_rst");

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 4) == 0) begin
        run_mt(1'($urandom_range(0, 1)), a, $sformatf("rnd%0d_mt", i));
      end else begin
        op = 3'($urandom_range(0, 7));
        if (op == 3'b101 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
        run_md(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $sformatf("rnd%0d_op%0d", i, op));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
